// File: rtl/m31_vector_scale_mc.sv
`default_nettype none
// ============================================================================
// Module      : m31_vector_scale_mc
// Description : Multi-cycle M31 (p = 2^31-1) scalar-by-vector multiply-add.
//               result[i] = (addend[i] + scalar * vec[i]) mod p, one element
//               per clock through a single shared multiply-add and reducer.
//               Broadcast counterpart of the M31 dot-product unit.
//
// Ports       : clk     - clock, rising edge
//               reset   - asynchronous reset, active low
//               start   - begin an operation (accepted in IDLE or DONE)
//               scalar  - broadcast multiplier
//               vec     - multiplicand vector, VECTOR_SIZE words
//               addend  - accumulate vector, VECTOR_SIZE words
//               result  - registered result vector, canonical [0, p-1]
//               busy    - operation in progress
//               valid   - result holds a completed operation
//
// Revision    : 1.0 - initial release
// ============================================================================
module m31_vector_scale_mc #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [WORD_WIDTH-1:0]                   scalar,
    input  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0]  vec,
    input  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0]  addend,
    output logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0]  result,
    output logic                                    busy,
    output logic                                    valid
);

    localparam int CNT_W = $clog2(VECTOR_SIZE);
    localparam int MAC_W = 2 * WORD_WIDTH + 1;

    // The modulus is the all-ones word (Mersenne prime).
    localparam logic [WORD_WIDTH-1:0] C_P    = '1;
    localparam logic [CNT_W-1:0]      C_LAST = CNT_W'(VECTOR_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                                  r_state;
    state_t                                  w_state_nxt;
    logic [CNT_W-1:0]                        r_cnt;
    logic [WORD_WIDTH-1:0]                   r_scalar;
    logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0]  r_vec;
    logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0]  r_addend;

    logic                   w_accept;
    logic                   w_write;
    logic                   w_last;
    logic [WORD_WIDTH-1:0]  w_vec_sel;
    logic [WORD_WIDTH-1:0]  w_add_sel;
    logic [MAC_W-1:0]       w_mac;
    logic [WORD_WIDTH+1:0]  w_f1;
    logic [WORD_WIDTH:0]    w_f2;
    logic [WORD_WIDTH-1:0]  w_f3;
    logic [WORD_WIDTH-1:0]  w_red;

    // ------------------------------------------------------------------------
    // Datapath: element select, multiply-add, Mersenne reduction
    // ------------------------------------------------------------------------
    assign w_last    = (r_cnt == C_LAST);
    assign w_vec_sel = r_vec[r_cnt];
    assign w_add_sel = r_addend[r_cnt];

    // Kept as one expression so the multiply and add map onto a single MACC.
    // Operands are at most p, so p*p + p fits in MAC_W bits.
    assign w_mac = MAC_W'(r_scalar) * MAC_W'(w_vec_sel) + MAC_W'(w_add_sel);

    // 2^W == 1 (mod p): fold the high part onto the low part.
    // First fold: < 2^W + 2^(W+1), needs W+2 bits.
    assign w_f1 = (WORD_WIDTH+2)'(w_mac[WORD_WIDTH-1:0])
                + (WORD_WIDTH+2)'(w_mac[MAC_W-1:WORD_WIDTH]);
    // Second fold: at most (2^W - 1) + 3, needs W+1 bits.
    assign w_f2 = (WORD_WIDTH+1)'(w_f1[WORD_WIDTH-1:0])
                + (WORD_WIDTH+1)'(w_f1[WORD_WIDTH+1:WORD_WIDTH]);
    // Third fold: if bit W is set the low part is tiny, so the sum fits W bits.
    assign w_f3 = w_f2[WORD_WIDTH-1:0] + WORD_WIDTH'(w_f2[WORD_WIDTH]);
    // p is the non-canonical encoding of zero.
    assign w_red = (w_f3 == C_P) ? '0 : w_f3;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_write     = 1'b0;
        busy        = 1'b0;
        valid       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // start is deliberately ignored here; nothing is queued.
                busy    = 1'b1;
                w_write = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                valid = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand capture, element counter and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_scalar <= '0;
            r_vec    <= '0;
            r_addend <= '0;
            result   <= '0;
        end else if (w_accept) begin
            // Snapshot operands so later input changes cannot disturb the run.
            r_cnt    <= '0;
            r_scalar <= scalar;
            r_vec    <= vec;
            r_addend <= addend;
        end else if (w_write) begin
            result[r_cnt] <= w_red;
            r_cnt         <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m31_vector_scale_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_m31_vector_scale_mc
// Description : Scoreboard bench for m31_vector_scale_mc. Stimulus pushes the
//               expected vector and the expected valid cycle; an independent
//               monitor pops and compares on every rising edge of valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m31_vector_scale_mc;

    localparam int W = 31;
    localparam int N = 16;
    localparam logic [W-1:0] P = 31'h7FFF_FFFF;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] scalar;
    vec_t         vec;
    vec_t         addend;
    vec_t         result;
    logic         busy;
    logic         valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    vec_t exp_q[$];
    int   lat_q[$];

    m31_vector_scale_mc #(
        .WORD_WIDTH (W),
        .VECTOR_SIZE(N)
    ) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .start (start),
        .scalar(scalar),
        .vec   (vec),
        .addend(addend),
        .result(result),
        .busy  (busy),
        .valid (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] mref(input logic [W-1:0] s, input logic [W-1:0] v,
                                          input logic [W-1:0] a);
        longint unsigned ls, lv, la, x;
        ls = 64'(s);
        lv = 64'(v);
        la = 64'(a);
        x  = (ls * lv + la) % 64'd2147483647;
        return x[W-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: compares on each valid rising edge
    // ------------------------------------------------------------------------
    logic prev_valid = 1'b0;
    vec_t mon_e;
    int   mon_l;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_valid_exclusive", longint'(busy & valid), 0);
            if (valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_l = lat_q.pop_front();
                    chk("valid_cycle", cyc, mon_l);
                    for (int i = 0; i < N; i++) begin
                        chk($sformatf("result[%0d]", i), longint'(result[i]), longint'(mon_e[i]));
                    end
                end
            end
        end
        prev_valid = valid;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic issue(input logic [W-1:0] s, input vec_t v, input vec_t a, input vec_t e,
                         input bit push, input bit hold);
        @(negedge clk);
        scalar = s;
        vec    = v;
        addend = a;
        start  = 1'b1;
        if (push) begin
            exp_q.push_back(e);
            lat_q.push_back(cyc + 1 + N);
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, longint'(valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        vec_t v, a, e;
        rst_n  = 1'b0;
        start  = 1'b0;
        scalar = '0;
        vec    = '0;
        addend = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_valid", longint'(valid), 0);
        chk("reset_result_zero", longint'(result == '0), 1);
        rst_n = 1'b1;

        // Basic: result[i] = 2i
        for (int i = 0; i < N; i++) begin
            v[i] = W'(i); a[i] = '0; e[i] = W'(2 * i);
        end
        issue(31'd2, v, a, e, 1'b1, 1'b0);
        chk("busy_after_start", longint'(busy), 1);
        chk("valid_after_start", longint'(valid), 0);
        wait_valid("basic_timeout");
        repeat (3) @(negedge clk);
        chk("done_hold_valid", longint'(valid), 1);
        chk("done_hold_r15", longint'(result[15]), 30);

        // (p-1)*1 + 5 = 4
        for (int i = 0; i < N; i++) begin
            v[i] = 31'd1; a[i] = 31'd5; e[i] = 31'd4;
        end
        issue(31'd2147483646, v, a, e, 1'b1, 1'b0);
        wait_valid("wrap1_timeout");

        // 2^30 * 2 = 2^31 = 1
        for (int i = 0; i < N; i++) begin
            v[i] = 31'd2; a[i] = '0; e[i] = 31'd1;
        end
        issue(31'h4000_0000, v, a, e, 1'b1, 1'b0);
        wait_valid("wrap2_timeout");

        // Non-canonical scalar: p*123 + i = i
        for (int i = 0; i < N; i++) begin
            v[i] = 31'd123; a[i] = W'(i); e[i] = W'(i);
        end
        issue(P, v, a, e, 1'b1, 1'b0);
        wait_valid("noncanon1_timeout");

        // Non-canonical addend with zero scalar: result 0
        for (int i = 0; i < N; i++) begin
            v[i] = W'(i + 7); a[i] = P; e[i] = '0;
        end
        issue(31'd0, v, a, e, 1'b1, 1'b0);
        wait_valid("noncanon2_timeout");

        // Mixed large operands
        for (int i = 0; i < N; i++) begin
            v[i] = P - 31'd1 - W'(i * 1000);
            a[i] = W'(i * 77777 + 1);
            e[i] = mref(31'h1234_5678, v[i], a[i]);
        end
        issue(31'h1234_5678, v, a, e, 1'b1, 1'b0);
        wait_valid("mixed_timeout");

        // Input capture and ignored start in RUN: 3*(i+1)+10
        for (int i = 0; i < N; i++) begin
            v[i] = W'(i + 1); a[i] = 31'd10; e[i] = W'(3 * (i + 1) + 10);
        end
        issue(31'd3, v, a, e, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        vec    = '0;
        scalar = '0;
        addend = '0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_valid("capture_timeout");
        repeat (20) @(negedge clk);
        chk("no_queued_start_valid", longint'(valid), 1);
        chk("no_queued_start_busy", longint'(busy), 0);

        // Back-to-back with start held high: op1 = 5*i + 1, op2 = 7*i + 2
        for (int i = 0; i < N; i++) begin
            v[i] = W'(i); a[i] = 31'd1; e[i] = W'(5 * i + 1);
        end
        issue(31'd5, v, a, e, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) begin
            v[i] = W'(i); a[i] = 31'd2; e[i] = W'(7 * i + 2);
        end
        scalar = 31'd7;
        vec    = v;
        addend = a;
        exp_q.push_back(e);
        lat_q.push_back(cyc + (N + 1) + N);
        wait_valid("b2b_first_timeout");
        @(negedge clk);
        chk("b2b_valid_one_cycle", longint'(valid), 0);
        chk("b2b_busy_again", longint'(busy), 1);
        start = 1'b0;
        wait_valid("b2b_second_timeout");

        // Reset in the middle of RUN
        for (int i = 0; i < N; i++) begin
            v[i] = W'(i + 100); a[i] = 31'd9; e[i] = '0;
        end
        issue(31'd11, v, a, e, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_valid", longint'(valid), 0);
        chk("midrst_result_zero", longint'(result == '0), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("postrst_valid", longint'(valid), 0);
        chk("postrst_busy", longint'(busy), 0);

        for (int i = 0; i < N; i++) begin
            v[i] = W'(i + 100); a[i] = 31'd9; e[i] = W'(11 * (i + 100) + 9);
        end
        issue(31'd11, v, a, e, 1'b1, 1'b0);
        wait_valid("postrst_op_timeout");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
